// File: rtl/bsg_fifo_credit_sender.sv
// rtl/bsg_fifo_credit_sender.sv - credit-counting transmit side of a registered FIFO link
//
// Purpose: accepts a valid/ready stream and forwards it over a registered link to a
//   remote FIFO of depth els_p. It holds one credit per free remote slot, so the
//   remote FIFO is never overrun. It also mirrors the remote write/read pointers
//   (wrap-bit encoding) so that both ends can be cross-checked.
// Optional feature: define BSG_FIFO_CREDIT_SENDER_TOKEN_EN to make each credit_i pulse a
//   token worth 2**lg_credit_decimation_p credits (the default is 1 credit per pulse).
// Ports:
//   clk_i, reset_i        clock (rising edge), synchronous active-high reset
//   v_i, data_i, ready_o  upstream stream; ready_o means a credit is available
//   v_o, data_o           registered link output, one cycle after the transfer
//   credit_i              remote dequeue return
//   credits_o             credits currently held
//   wptr_r_o, rptr_r_o    mirrored remote pointers, MSB is the wrap bit
//   full_o, empty_o       remote FIFO full / empty
//   error_o               sticky credit-overflow flag
module bsg_fifo_credit_sender #(
  parameter int width_p                = 32,
  parameter int els_p                  = 32,
  parameter int lg_credit_decimation_p = 2,
  localparam int ptr_width_lp          = $clog2(els_p) + 1,
  localparam int cnt_width_lp          = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    credit_i,
  output logic [cnt_width_lp-1:0] credits_o,
  output logic [ptr_width_lp-1:0] wptr_r_o,
  output logic [ptr_width_lp-1:0] rptr_r_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    error_o
);

`ifdef BSG_FIFO_CREDIT_SENDER_TOKEN_EN
  localparam int lg_inc_lp = lg_credit_decimation_p;
`else
  // Without tokens every pulse is a single credit; the decimation is ignored.
  localparam int lg_inc_lp = lg_credit_decimation_p * 0;
`endif

  localparam logic [cnt_width_lp:0]   els_lp     = (cnt_width_lp+1)'(els_p);
  localparam logic [cnt_width_lp:0]   inc_cnt_lp = (cnt_width_lp+1)'(1 << lg_inc_lp);
  localparam logic [ptr_width_lp-1:0] inc_ptr_lp = ptr_width_lp'(1 << lg_inc_lp);
  localparam logic [ptr_width_lp-1:0] one_ptr_lp = ptr_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] one_cnt_lp = cnt_width_lp'(1);

  logic [cnt_width_lp-1:0] credits_r, credits_n;
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic                    v_r, error_r;
  logic [width_p-1:0]      data_r;
  logic [cnt_width_lp:0]   credit_sum;
  logic                    send, overflow, credit_ok;

  // Ready depends on held state only, so a credit arriving while full does not
  // open the gate until the following cycle.
  assign ready_o    = (credits_r != '0) & ~reset_i;
  assign send       = v_i & ready_o;

  // One extra bit so the overflow compare cannot wrap.
  assign credit_sum = {1'b0, credits_r} + inc_cnt_lp;
  assign overflow   = credit_i & (credit_sum > els_lp);
  assign credit_ok  = credit_i & ~overflow;

  always_comb begin
    credits_n = credits_r;
    if (overflow) begin
      credits_n = els_lp[cnt_width_lp-1:0];
    end else if (credit_ok) begin
      credits_n = credit_sum[cnt_width_lp-1:0];
    end
    if (send) begin
      credits_n = credits_n - one_cnt_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r <= els_lp[cnt_width_lp-1:0];
      wptr_r    <= '0;
      rptr_r    <= '0;
      v_r       <= 1'b0;
      data_r    <= '0;
      error_r   <= 1'b0;
    end else begin
      credits_r <= credits_n;
      v_r       <= send;
      if (send) begin
        data_r <= data_i;
        wptr_r <= wptr_r + one_ptr_lp;
      end
      // An overflowing return is rejected: the read pointer stays put.
      if (credit_ok) begin
        rptr_r <= rptr_r + inc_ptr_lp;
      end
      if (overflow) begin
        error_r <= 1'b1;
      end
    end
  end

  assign v_o       = v_r;
  assign data_o    = data_r;
  assign credits_o = credits_r;
  assign wptr_r_o  = wptr_r;
  assign rptr_r_o  = rptr_r;
  assign full_o    = (credits_r == '0);
  assign empty_o   = (credits_r == els_lp[cnt_width_lp-1:0]);
  assign error_o   = error_r;

endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
// tb/tb_bsg_fifo_credit_sender.sv - self-checking bench for bsg_fifo_credit_sender
module tb_bsg_fifo_credit_sender;

  localparam int W   = 32;
  localparam int ELS = 32;
`ifdef BSG_FIFO_CREDIT_SENDER_TOKEN_EN
  localparam int INC = 4;
`else
  localparam int INC = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         credit_i = 1'b0;
  logic         ready_o, v_o, full_o, empty_o, error_o;
  logic [W-1:0] data_o;
  logic [5:0]   credits_o, wptr_r_o, rptr_r_o;

  bsg_fifo_credit_sender #(
    .width_p(W), .els_p(ELS), .lg_credit_decimation_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .credit_i(credit_i), .credits_o(credits_o),
    .wptr_r_o(wptr_r_o), .rptr_r_o(rptr_r_o), .full_o(full_o), .empty_o(empty_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           m_cred = ELS;
  logic [5:0]   m_w = '0;
  logic [5:0]   m_r = '0;
  logic         m_err = 1'b0;
  logic         m_v = 1'b0;
  logic [W-1:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference from the inputs the DUT sees at this edge,
  // then compare everything 1 time unit later.
  task automatic tick();
    logic send, ov;
    int   sum;
    @(posedge clk);
    if (reset_i) begin
      m_cred = ELS; m_w = '0; m_r = '0; m_err = 1'b0; m_v = 1'b0;
      sb.delete();
    end else begin
      send = v_i && (m_cred != 0);
      sum  = m_cred + INC;
      ov   = credit_i && (sum > ELS);
      if (ov) begin
        m_err = 1'b1;
        m_cred = ELS;
      end else if (credit_i) begin
        m_cred = sum;
        m_r = m_r + 6'(INC);
      end
      if (send) begin
        m_cred = m_cred - 1;
        m_w = m_w + 6'd1;
        sb.push_back(data_i);
      end
      m_v = send;
    end
    #1;
    check("credits", credits_o, m_cred);
    check("wptr", wptr_r_o, m_w);
    check("rptr", rptr_r_o, m_r);
    check("error", error_o, m_err);
    check("full", full_o, m_cred == 0);
    check("empty", empty_o, m_cred == ELS);
    check("ready", ready_o, (m_cred != 0) && !reset_i);
    check("v_o", v_o, m_v);
    if (v_o) begin
      if (sb.size() != 0) check("data", data_o, sb.pop_front());
      else check("sb_level", sb.size(), 1);
    end
  endtask

  initial begin
    // 1: reset, then idle
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    repeat (3) tick();
    check("t1_credits", credits_o, 32);
    check("t1_empty", empty_o, 1);
    check("t1_ready", ready_o, 1);
    check("t1_ptrs", {wptr_r_o, rptr_r_o}, 12'h0);

    // 2: fill with 32 back-to-back sends
    for (int k = 0; k < 32; k++) begin
      v_i = 1'b1; data_i = W'(k);
      tick();
    end
    v_i = 1'b0;
    check("t2_full", full_o, 1);
    check("t2_ready", ready_o, 0);
    check("t2_wptr", wptr_r_o, 6'b100000);

    // 3: hold v_i while full, a credit does not open ready in its own cycle
    v_i = 1'b1; data_i = 32'hCAFE_0099;
    repeat (3) tick();
    credit_i = 1'b1;
    tick();
    check("t3_no_v", v_o, 0);
    credit_i = 1'b0;
    tick();
    check("t3_v", v_o, 1);
    v_i = 1'b0;
    check("t3_wptr", wptr_r_o, 6'b100001);
    check("t3_rptr", rptr_r_o, 6'(INC));

`ifndef BSG_FIFO_CREDIT_SENDER_TOKEN_EN
    // 4: steady state at 5 credits, pointers wrap
    credit_i = 1'b1;
    repeat (5) tick();
    v_i = 1'b1;
    for (int c = 0; c < 70; c++) begin
      data_i = $urandom;
      tick();
      check("t4_credits", credits_o, 5);
    end
    v_i = 1'b0;
    for (int c = 0; c < 100 && m_cred < ELS; c++) tick();
    credit_i = 1'b0;
    check("t4_empty", empty_o, 1);

    // 5: overflow at 32 credits is sticky until reset
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    check("t5_err", error_o, 1);
    check("t5_credits", credits_o, 32);
    repeat (3) tick();
    check("t5_err_sticky", error_o, 1);
    v_i = 1'b1; data_i = 32'h1234_5678;
    tick();
    reset_i = 1'b1;
    tick();
    check("t5_rst_no_v", v_o, 0);
    reset_i = 1'b0; v_i = 1'b0;
    tick();
    check("t5_err_clr", error_o, 0);
`else
    // 6: token credits
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    v_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      data_i = W'(k + 100);
      tick();
    end
    v_i = 1'b0;
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    check("t6_credits4", credits_o, 4);
    check("t6_rptr4", rptr_r_o, 6'd4);
    credit_i = 1'b1; repeat (7) tick(); credit_i = 1'b0;
    v_i = 1'b1; repeat (2) tick(); v_i = 1'b0;
    check("t6_credits30", credits_o, 30);
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    check("t6_err", error_o, 1);
    check("t6_sat", credits_o, 32);
`endif

    tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
